// File: rtl/simple_pkg.sv
// rtl/simple_pkg.sv - SIMPLE decode types, field codes and decode/source helpers
package simple_pkg;

    localparam int REG_W = 3;

    localparam logic [1:0] FMT_LD  = 2'b00;
    localparam logic [1:0] FMT_ST  = 2'b01;
    localparam logic [1:0] FMT_IMM = 2'b10;
    localparam logic [1:0] FMT_ALU = 2'b11;

    localparam logic [2:0] SUB_LI   = 3'b000;
    localparam logic [2:0] SUB_ADDI = 3'b010;
    localparam logic [2:0] SUB_CMPI = 3'b011;
    localparam logic [2:0] SUB_B    = 3'b100;
    localparam logic [2:0] SUB_SLI  = 3'b101;
    localparam logic [2:0] SUB_BR   = 3'b111;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_CMP  = 4'b0101;
    localparam logic [3:0] OP_MOV  = 4'b0110;
    localparam logic [3:0] OP_RSV7 = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_IN   = 4'b1100;
    localparam logic [3:0] OP_OUT  = 4'b1101;
    localparam logic [3:0] OP_RSVE = 4'b1110;
    localparam logic [3:0] OP_HLT  = 4'b1111;

    typedef struct packed {
        logic             RegWrite;
        logic             MemRead;
        logic             MemWrite;
        logic             MemtoReg;
        logic             ALUSrc1;
        logic             ALUSrc2;
        logic             Output;
        logic             Input;
        logic             ALUorShifter;
        logic             Halt;
        logic             AS_BC;
        logic             SLI;
        logic [3:0]       opcode;
        logic [REG_W-1:0] RegDst;
        logic [2:0]       Branch;
    } ctl_t;

    typedef struct packed {
        logic             v1;
        logic [REG_W-1:0] r1;
        logic             v2;
        logic [REG_W-1:0] r2;
    } src_t;

    localparam ctl_t CTL_RESET = '{Branch: 3'b111, default: '0};

    function automatic ctl_t decode(input logic [15:0] inst);
        ctl_t       c;
        logic [1:0] fmt;
        logic [2:0] sub;
        logic [3:0] op;
        fmt = inst[15:14];
        sub = inst[13:11];
        op  = inst[7:4];
        c   = CTL_RESET;
        case (fmt)
            FMT_ALU: begin
                c.RegWrite     = !(op inside {OP_CMP, OP_RSV7, OP_OUT, OP_RSVE, OP_HLT});
                c.ALUSrc2      = (op > OP_MOV);
                c.ALUorShifter = (op[3:2] == 2'b10);
                c.Input        = (op == OP_IN);
                c.Output       = (op == OP_OUT);
                c.Halt         = (op == OP_HLT);
                c.AS_BC        = (op <= OP_MOV);
                c.opcode       = op;
                c.RegDst       = inst[10:8];
            end
            FMT_LD: begin
                c.MemRead  = 1'b1;
                c.MemtoReg = 1'b1;
                c.RegWrite = 1'b1;
                c.ALUSrc2  = 1'b1;
                c.opcode   = OP_ADD;
                c.RegDst   = inst[13:11];
            end
            FMT_ST: begin
                c.MemWrite = 1'b1;
                c.ALUSrc2  = 1'b1;
                c.opcode   = OP_ADD;
            end
            default: begin
                case (sub)
                    SUB_LI: begin
                        c.RegWrite = 1'b1;
                        c.ALUSrc1  = 1'b1;
                        c.ALUSrc2  = 1'b1;
                        c.opcode   = OP_MOV;
                        c.RegDst   = inst[10:8];
                    end
                    SUB_ADDI: begin
                        c.RegWrite = 1'b1;
                        c.ALUSrc2  = 1'b1;
                        c.AS_BC    = 1'b1;
                        c.opcode   = OP_ADD;
                        c.RegDst   = inst[10:8];
                    end
                    SUB_CMPI: begin
                        c.ALUSrc2 = 1'b1;
                        c.AS_BC   = 1'b1;
                        c.opcode  = OP_CMP;
                    end
                    SUB_SLI: begin
                        c.RegWrite     = 1'b1;
                        c.ALUSrc2      = 1'b1;
                        c.SLI          = 1'b1;
                        c.ALUorShifter = 1'b1;
                        c.opcode       = OP_SLL;
                        c.RegDst       = inst[10:8];
                    end
                    SUB_B:   c.Branch = 3'b100;
                    SUB_BR:  c.Branch = inst[10:8];
                    default: c.Branch = 3'b111;
                endcase
            end
        endcase
        return c;
    endfunction

    function automatic src_t srcs(input logic [15:0] inst);
        src_t s;
        s = '0;
        case (inst[15:14])
            FMT_ALU: begin
                s.v1 = 1'b1;
                s.r1 = inst[13:11];
                s.v2 = (inst[7:4] <= OP_MOV);
                s.r2 = inst[10:8];
            end
            FMT_LD: begin
                s.v1 = 1'b1;
                s.r1 = inst[10:8];
            end
            FMT_ST: begin
                s.v1 = 1'b1;
                s.r1 = inst[13:11];
                s.v2 = 1'b1;
                s.r2 = inst[10:8];
            end
            default: begin
                s.v1 = inst[13:11] inside {SUB_ADDI, SUB_CMPI, SUB_SLI};
                s.r1 = inst[10:8];
            end
        endcase
        return s;
    endfunction

endpackage

// File: rtl/hazard_sb.sv
// rtl/hazard_sb.sv - in-flight writer scoreboard and RAW stall compare
module hazard_sb #(
    parameter int SB_DEPTH   = 3,
    parameter int FORWARD_EN = 1,
    parameter int REG_AW     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_valid,
    input  logic [REG_AW-1:0] push_dst,
    input  logic              push_load,
    input  logic              src1_v,
    input  logic [REG_AW-1:0] src1,
    input  logic              src2_v,
    input  logic [REG_AW-1:0] src2,
    output logic              stall
);

    logic [SB_DEPTH-1:0] ent_valid;
    logic [REG_AW-1:0]   ent_dst [SB_DEPTH];
    // Only the youngest entry's load flag is ever consulted, so it is not shifted on.
    logic                ent0_load;
    logic [SB_DEPTH-1:0] hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_valid <= '0;
            ent0_load <= 1'b0;
            for (int i = 0; i < SB_DEPTH; i++) begin
                ent_dst[i] <= '0;
            end
        end else begin
            ent_valid[0] <= push_valid;
            ent_dst[0]   <= push_dst;
            ent0_load    <= push_load;
            for (int i = 1; i < SB_DEPTH; i++) begin
                ent_valid[i] <= ent_valid[i-1];
                ent_dst[i]   <= ent_dst[i-1];
            end
        end
    end

    always_comb begin
        hit = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            hit[i] = ent_valid[i] && ((src1_v && (src1 == ent_dst[i])) ||
                                      (src2_v && (src2 == ent_dst[i])));
        end
    end

    assign stall = (FORWARD_EN != 0) ? (hit[0] && ent0_load) : (|hit);

endmodule

// File: rtl/ctl_pipe.sv
// rtl/ctl_pipe.sv - SIMPLE decode stage: ID/EX control register, hazard stall, flush, halt
module ctl_pipe
    import simple_pkg::*;
#(
    parameter int SB_DEPTH   = 3,
    parameter int FORWARD_EN = 1,
    parameter int REG_AW     = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] in_inst,
    output logic        in_ready,
    input  logic        flush,
    output logic        ex_valid,
    output ctl_t        ex_ctl,
    output logic        stall,
    output logic        halted
);

    ctl_t dec;
    src_t src;
    logic issue;

    assign dec      = decode(in_inst);
    assign src      = srcs(in_inst);
    // A flush consumes the instruction even when it would otherwise stall.
    assign in_ready = in_valid && !halted && (!stall || flush);
    assign issue    = in_ready && !flush;

    hazard_sb #(
        .SB_DEPTH  (SB_DEPTH),
        .FORWARD_EN(FORWARD_EN),
        .REG_AW    (REG_AW)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_valid(issue && dec.RegWrite),
        .push_dst  (REG_AW'(dec.RegDst)),
        .push_load (dec.MemRead),
        .src1_v    (in_valid && src.v1),
        .src1      (REG_AW'(src.r1)),
        .src2_v    (in_valid && src.v2),
        .src2      (REG_AW'(src.r2)),
        .stall     (stall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid <= 1'b0;
            ex_ctl   <= CTL_RESET;
            halted   <= 1'b0;
        end else begin
            ex_valid <= issue;
            ex_ctl   <= issue ? dec : CTL_RESET;
            if (issue && dec.Halt) begin
                halted <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ctl_pipe.sv
// tb/tb_ctl_pipe.sv - directed bench for ctl_pipe with per-cycle reference model
module tb_ctl_pipe;
    import simple_pkg::*;

    localparam int DEPTH = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid [2];
    logic [15:0] in_inst  [2];
    logic        flush    [2];
    logic        in_ready [2];
    logic        ex_valid [2];
    logic        stall    [2];
    logic        halted   [2];
    ctl_t        ex_ctl   [2];

    always #5 clk = ~clk;

    // Instance 0 forwards (load-use only); instance 1 stalls on any in-flight writer.
    ctl_pipe #(.SB_DEPTH(DEPTH), .FORWARD_EN(1), .REG_AW(3)) u_fe1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_inst(in_inst[0]),
        .in_ready(in_ready[0]), .flush(flush[0]), .ex_valid(ex_valid[0]),
        .ex_ctl(ex_ctl[0]), .stall(stall[0]), .halted(halted[0]));

    ctl_pipe #(.SB_DEPTH(DEPTH), .FORWARD_EN(0), .REG_AW(3)) u_fe0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_inst(in_inst[1]),
        .in_ready(in_ready[1]), .flush(flush[1]), .ex_valid(ex_valid[1]),
        .ex_ctl(ex_ctl[1]), .stall(stall[1]), .halted(halted[1]));

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic ctl_t exp_reset();
        ctl_t c;
        c = '0;
        c.Branch = 3'b111;
        return c;
    endfunction

    // Mnemonic-level expectations for each instruction class.
    function automatic ctl_t model_ctl(input logic [15:0] w);
        ctl_t c;
        int   o;
        int   s;
        c = exp_reset();
        o = int'(w[7:4]);
        s = int'(w[13:11]);
        if (w[15:14] == 2'b11) begin
            c.opcode = w[7:4];
            c.RegDst = w[10:8];
            case (o)
                0, 1, 2, 3, 4, 6: begin c.RegWrite = 1; c.AS_BC = 1; end
                5:                c.AS_BC = 1;
                8, 9, 10, 11:     begin c.RegWrite = 1; c.ALUorShifter = 1; c.ALUSrc2 = 1; end
                12:               begin c.RegWrite = 1; c.Input = 1; c.ALUSrc2 = 1; end
                13:               begin c.Output = 1; c.ALUSrc2 = 1; end
                15:               begin c.Halt = 1; c.ALUSrc2 = 1; end
                default:          c.ALUSrc2 = 1;
            endcase
        end else if (w[15:14] == 2'b00) begin
            c.MemRead = 1; c.MemtoReg = 1; c.RegWrite = 1; c.ALUSrc2 = 1;
            c.RegDst = w[13:11];
        end else if (w[15:14] == 2'b01) begin
            c.MemWrite = 1; c.ALUSrc2 = 1;
        end else begin
            case (s)
                0: begin c.RegWrite = 1; c.ALUSrc1 = 1; c.ALUSrc2 = 1; c.opcode = 4'd6; c.RegDst = w[10:8]; end
                2: begin c.RegWrite = 1; c.ALUSrc2 = 1; c.AS_BC = 1; c.RegDst = w[10:8]; end
                3: begin c.ALUSrc2 = 1; c.AS_BC = 1; c.opcode = 4'd5; end
                5: begin c.RegWrite = 1; c.ALUSrc2 = 1; c.SLI = 1; c.ALUorShifter = 1; c.opcode = 4'd8; c.RegDst = w[10:8]; end
                4: c.Branch = 3'b100;
                7: c.Branch = w[10:8];
                default: c.Branch = 3'b111;
            endcase
        end
        return c;
    endfunction

    function automatic void model_srcs(input logic [15:0] w, output int n, output int ra, output int rb);
        n  = 0;
        ra = int'(w[13:11]);
        rb = int'(w[10:8]);
        case (w[15:14])
            2'b11: n = (w[7:4] <= 4'd6) ? 2 : 1;
            2'b01: n = 2;
            2'b00: begin n = 1; ra = int'(w[10:8]); end
            default: begin
                ra = int'(w[10:8]);
                n  = (w[13:11] == 3'd2 || w[13:11] == 3'd3 || w[13:11] == 3'd5) ? 1 : 0;
            end
        endcase
    endfunction

    // Per-register issue cycle of the latest writer and whether it was a load.
    int   m_last [2][8];
    bit   m_ld   [2][8];
    bit   m_halt [2];
    bit   m_exv  [2];
    ctl_t m_ctl  [2];
    int   m_cyc  [2];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                chk("rst_ex_valid", 32'(ex_valid[d]), 32'd0);
                chk("rst_ex_ctl", 32'(ex_ctl[d]), 32'(exp_reset()));
                chk("rst_halted", 32'(halted[d]), 32'd0);
                chk("rst_stall", 32'(stall[d]), 32'd0);
                for (int r = 0; r < 8; r++) begin
                    m_last[d][r] = -100;
                    m_ld[d][r]   = 1'b0;
                end
                m_halt[d] = 1'b0;
                m_exv[d]  = 1'b0;
                m_ctl[d]  = exp_reset();
                m_cyc[d]  = 0;
            end else begin
                int   n, ra, rb, age;
                bit   hz, se, re;
                ctl_t c;
                chk("ex_valid", 32'(ex_valid[d]), 32'(m_exv[d]));
                chk("ex_ctl", 32'(ex_ctl[d]), 32'(m_ctl[d]));
                chk("halted", 32'(halted[d]), 32'(m_halt[d]));
                model_srcs(in_inst[d], n, ra, rb);
                hz = 1'b0;
                for (int k = 0; k < n; k++) begin
                    int r;
                    r   = (k == 0) ? ra : rb;
                    age = m_cyc[d] - m_last[d][r];
                    if (d == 0) hz = hz | (age == 1 && m_ld[d][r]);
                    else        hz = hz | (age >= 1 && age <= DEPTH);
                end
                se = in_valid[d] && hz;
                re = in_valid[d] && !m_halt[d] && (!se || flush[d]);
                chk("stall", 32'(stall[d]), 32'(se));
                chk("in_ready", 32'(in_ready[d]), 32'(re));
                if (re && !flush[d]) begin
                    c = model_ctl(in_inst[d]);
                    m_exv[d] = 1'b1;
                    m_ctl[d] = c;
                    if (c.RegWrite) begin
                        m_last[d][c.RegDst] = m_cyc[d];
                        m_ld[d][c.RegDst]   = c.MemRead;
                    end
                    if (c.Halt) m_halt[d] = 1'b1;
                end else begin
                    m_exv[d] = 1'b0;
                    m_ctl[d] = exp_reset();
                end
                m_cyc[d]++;
            end
        end
    end

    // Presents one instruction until accepted; returns the number of stalled cycles.
    task automatic send(input int d, input logic [15:0] w, input bit fl, output int waits);
        bit done;
        in_valid[d] = 1'b1;
        in_inst[d]  = w;
        flush[d]    = fl;
        waits = 0;
        done  = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (in_ready[d]) done = 1'b1;
            else begin
                waits++;
                if (waits > 10) begin
                    chk("send_timeout", 32'(waits), 32'd0);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
        flush[d]    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [15:0] tbl [12] = '{16'h8507, 16'h9501, 16'h9D00, 16'hAA03, 16'hA004, 16'hBB00,
                              16'h1000, 16'h4A00, 16'hCA80, 16'hC6C0, 16'hF0D0, 16'hDC00};

    initial begin
        int w;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 1'b0;
            in_inst[d]  = 16'h0000;
            flush[d]    = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("reset_ex_valid", 32'(ex_valid[0]), 32'd0);
        chk("reset_branch", 32'(ex_ctl[0].Branch), 32'h7);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        send(0, 16'hD100, 1'b0, w);
        chk("add_waits", 32'(w), 32'd0);
        chk("add_ex_valid", 32'(ex_valid[0]), 32'd1);
        chk("add_regwrite", 32'(ex_ctl[0].RegWrite), 32'd1);
        chk("add_alusrc2", 32'(ex_ctl[0].ALUSrc2), 32'd0);
        chk("add_as_bc", 32'(ex_ctl[0].AS_BC), 32'd1);
        chk("add_regdst", 32'(ex_ctl[0].RegDst), 32'd1);
        idle(4);

        send(0, 16'h1800, 1'b0, w);
        send(0, 16'hDC00, 1'b0, w);
        chk("loaduse_fe1_bubbles", 32'(w), 32'd1);
        idle(4);

        send(1, 16'h1800, 1'b0, w);
        send(1, 16'hDC00, 1'b0, w);
        chk("loaduse_fe0_bubbles", 32'(w), 32'd3);
        idle(4);
        send(1, 16'h1800, 1'b0, w);
        send(1, 16'hD100, 1'b0, w);
        chk("independent_fe0_bubbles", 32'(w), 32'd0);
        idle(4);

        send(0, 16'h1800, 1'b0, w);
        send(0, 16'h2300, 1'b1, w);
        chk("flush_stalled_waits", 32'(w), 32'd0);
        chk("flush_bubble", 32'(ex_valid[0]), 32'd0);
        send(0, 16'hDC00, 1'b0, w);
        chk("after_flush_no_stall", 32'(w), 32'd0);
        idle(4);

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 12; i++) send(d, tbl[i], 1'b0, w);
            idle(4);
        end

        send(0, 16'hC0F0, 1'b1, w);
        chk("hlt_flush_halted", 32'(halted[0]), 32'd0);
        chk("hlt_flush_bubble", 32'(ex_valid[0]), 32'd0);
        send(0, 16'hC0F0, 1'b0, w);
        chk("hlt_ctl_halt", 32'(ex_ctl[0].Halt), 32'd1);
        chk("hlt_halted", 32'(halted[0]), 32'd1);
        in_valid[0] = 1'b1;
        in_inst[0]  = 16'hD100;
        @(negedge clk);
        chk("halted_in_ready", 32'(in_ready[0]), 32'd0);
        repeat (2) @(negedge clk);
        chk("halted_sticky", 32'(halted[0]), 32'd1);
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;

        send(1, 16'h1800, 1'b0, w);
        in_valid[1] = 1'b1;
        in_inst[1]  = 16'hDC00;
        @(negedge clk);
        chk("pre_reset_stall", 32'(stall[1]), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_stall", 32'(stall[1]), 32'd0);
        chk("async_rst_ex_valid", 32'(ex_valid[1]), 32'd0);
        chk("async_rst_halted", 32'(halted[0]), 32'd0);
        chk("async_rst_ctl", 32'(ex_ctl[0]), 32'(exp_reset()));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_stall", 32'(stall[1]), 32'd0);
        chk("post_reset_in_ready", 32'(in_ready[1]), 32'd1);
        @(posedge clk);
        #1;
        in_valid[1] = 1'b0;
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ctl_pipe.md
# ctl_pipe

Registered decode stage for the SIMPLE 16-bit pipeline. It sits between the IF/ID register and EX. The stage:
- decodes each accepted instruction into the control bundle and latches it into the ID/EX register;
- tracks in-flight register writers in a scoreboard and stalls fetch on RAW hazards;
- applies branch flushes;
- latches a sticky halt.

Downstream of ID never stalls, so the scoreboard advances every cycle.

## Interface
Parameters:
- `SB_DEPTH`, default 3: scoreboard entries, one per in-flight stage (EX, MEM, WB).
- `FORWARD_EN`, default 1: 1 stalls only on load-use against entry 0; 0 stalls on any match with any valid writer entry.
- `REG_AW`, default 3: register address width.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: IF/ID holds a valid instruction.
- `in_inst` input 16: instruction word.
- `in_ready` output 1: instruction accepted this cycle.
- `flush` input 1: branch taken in EX; the current ID instruction is killed.
- `ex_valid` output 1: ID/EX holds a real instruction; 0 means bubble.
- `ex_ctl` output struct `ctl_t`: registered control bundle.
- `stall` output 1: hazard stall active, combinational.
- `halted` output 1: sticky halt.

## Operation
Fields:
- `fmt` = `inst[15:14]`
- `sub` = `inst[13:11]`
- `cond` = `inst[10:8]`
- `op` = `inst[7:4]`

Decode is done by package function `decode()`. Each fmt row gives the bundle fields, then the RAW sources.
- fmt 11: RegWrite=1 except op ∈ {0101, 0111, 1101, 1110, 1111}. ALUSrc2=0 for op ≤ 0110. Shifter for op 10xx. In for op 1100, Out for op 1101, Halt for op 1111. RegDst=`inst[10:8]`. Sources: `inst[13:11]`, plus `inst[10:8]` for op ≤ 0110.
- fmt 00 (LD): MemRead=1, MemtoReg=1, RegWrite=1, RegDst=`inst[13:11]`. Source: `inst[10:8]`.
- fmt 01 (ST): MemWrite=1. Sources: `inst[13:11]` and `inst[10:8]`.
- fmt 10: LI(000), ADDI(010), CMPI(011) and SLI(101) follow the existing control rules. B(100) sets Branch=100. BR(111) sets Branch=`cond`. Otherwise Branch=111. Source: `inst[10:8]` for ADDI, CMPI and SLI.

Scoreboard entry: {valid, dst, is_load}.
- Every cycle entry[i+1] ← entry[i].
- Entry[0] ← {accepted && !flush && RegWrite, RegDst, MemRead}.

Stall condition:
- A source matches a valid entry, and
- either FORWARD_EN=0 (any entry), or FORWARD_EN=1 and the match is on entry[0] with is_load=1.

`in_ready` = `in_valid && !halted && (!stall || flush)`.

ID/EX update on each edge:
- Loads decode(in_inst) with `ex_valid`=1 when accepted and not flushed.
- Otherwise loads a bubble: `ex_valid`=0 and every ctl field at its reset value.

Halt:
- `halted` sets on the edge after an accepted, unflushed HLT.
- It stays set until `rst_n` is asserted; `in_ready`=0 while halted.

## Timing
- Reset values: `ex_valid`=0; all ctl bits 0; opcode=0; RegDst=0; Branch=111; scoreboard all invalid; `halted`=0.
- Decode latency is 1 cycle from acceptance to `ex_ctl`.
- Load-use penalty is 1 bubble with FORWARD_EN=1. With FORWARD_EN=0 the penalty is up to SB_DEPTH bubbles.
- Flush and stall in the same cycle: flush wins. The instruction is consumed and dropped, and a bubble is inserted.
- Flush in the same cycle as an HLT decode: HLT is killed and `halted` stays 0.
- `stall` does not depend on `flush`.
- Reset asserted mid-stall: the next edge after release starts clean, with no residual stall.
- Register r0 is not special; a dst of 0 is compared like any other register.

## Structure
- `simple_pkg` holds:
  - `ctl_t` packed struct with fields RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc1, ALUSrc2, Output, Input, ALUorShifter, Halt, AS_BC, SLI, opcode[3:0], RegDst, Branch[2:0];
  - `CTL_RESET` constant;
  - fmt/sub/op localparams;
  - `decode()` and `srcs()` functions.
- One sub-module, `hazard_sb`: the scoreboard shift register plus the compare logic. It is parametrised by SB_DEPTH, FORWARD_EN and REG_AW.

## Test plan
- Reset check: after reset, `ex_valid`=0 and Branch=111. Then ADD r1,r2 (`0xD100`-style encoding, fmt 11, op 0000) → next cycle RegWrite=1, ALUSrc2=0, AS_BC=1, RegDst=1.
- Load-use, FORWARD_EN=1: LD r3 then ADD r3,r4 with r3 as a source → `stall`=1 for 1 cycle, one bubble, then ADD issues.
- Same sequence with FORWARD_EN=0 and SB_DEPTH=3 → 3 bubbles. An independent ADD issues with 0 bubbles.
- `flush` asserted while a stalled ADD waits → `in_ready`=1, next `ex_valid`=0, scoreboard entry[0] invalid.
- HLT (fmt 11, op 1111) → `ex_ctl.Halt`=1 and `halted`=1 from the next cycle; `in_ready` stays 0. HLT with `flush` in the same cycle → `halted` stays 0.
- `rst_n` pulsed low mid-stall → all outputs return to reset values asynchronously and `stall`=0 after release.
